// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver: scan-code set 2
// prefixes, receiver FSM states and the key-event record stored in the FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam int         EVENT_W   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX    = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  // Frame layout LSB-first: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  function automatic logic frame_ok(input logic [10:0] frame);
    return !frame[0] && frame[10] && (^frame[9:1]);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO with registered pointers; an extra
// pointer bit distinguishes full from empty. Pushes into a full FIFO are dropped.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;
  assign rdata_o = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty/full come from the pointers
  // alone, so stale entries are never observable and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host receiver: pin synchronisers, ps2c glitch filter, frame FSM,
// set-2 prefix decoder and key-event FIFO. Define REPEAT_FILTER_EN to suppress typematic makes.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       parity_err,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  input  logic       key_rd,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic           ps2c_meta_q, ps2c_sync_q, ps2d_meta_q, ps2d_sync_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall_tick_q;

  rx_state_e      state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [10:0]    shift_q, shift_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           rx_done, frame_err;
  logic [7:0]     dout_q;

  logic           ext_q, ext_d, brk_q, brk_d;
  logic           push_q, push_d;
  key_event_t     ev_q, ev_d;
  logic           overflow_q;
`ifdef REPEAT_FILTER_EN
  logic [8:0]     last_make_q, last_make_d;
  logic           last_make_vld_q, last_make_vld_d;
`endif

  logic [EVENT_W-1:0] head_raw;
  key_event_t         head;
  logic               fifo_empty, fifo_drop;

  // Filter: flip only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (ps2c_sync_q != filt_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) filt_d = ps2c_sync_q;
      else                                    filt_cnt_d = filt_cnt_q + FCW'(1);
    end
  end

  // NOTE: every always_comb output is given a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    rx_done   = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_tick_q && rx_en) begin
          shift_d   = {ps2d_sync_q, shift_q[10:1]};
          bit_cnt_d = 4'd1;
          tmo_d     = '0;
          state_d   = RX;
        end
      end
      RX: begin
        if (fall_tick_q) begin
          shift_d = {ps2d_sync_q, shift_q[10:1]};
          tmo_d   = '0;
          if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = '0;
            state_d   = CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          frame_err = 1'b1;
          bit_cnt_d = '0;
          tmo_d     = '0;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok(shift_q)) rx_done   = 1'b1;
        else                   frame_err = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Prefix decoder: E0/F0 only arm flags; any other byte becomes an event.
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    push_d = 1'b0;
    ev_d   = ev_q;
`ifdef REPEAT_FILTER_EN
    last_make_d     = last_make_q;
    last_make_vld_d = last_make_vld_q;
`endif
    if (rx_done) begin
      if (shift_q[8:1] == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q[8:1] == PS2_BREAK) begin
        brk_d = 1'b1;
      end else begin
        ev_d   = '{ext: ext_q, brk: brk_q, code: shift_q[8:1]};
        push_d = 1'b1;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
`ifdef REPEAT_FILTER_EN
        if (!brk_q) begin
          if (last_make_vld_q && (last_make_q == {ext_q, shift_q[8:1]})) begin
            push_d = 1'b0;
          end else begin
            last_make_d     = {ext_q, shift_q[8:1]};
            last_make_vld_d = 1'b1;
          end
        end else if (last_make_q == {ext_q, shift_q[8:1]}) begin
          last_make_vld_d = 1'b0;
        end
`endif
      end
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      fall_tick_q <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      dout_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      push_q      <= 1'b0;
      ev_q        <= '0;
      overflow_q  <= 1'b0;
    end else begin
      ps2c_meta_q <= ps2c;
      ps2c_sync_q <= ps2c_meta_q;
      ps2d_meta_q <= ps2d;
      ps2d_sync_q <= ps2d_meta_q;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      fall_tick_q <= filt_q && !filt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      if (rx_done) dout_q <= shift_q[8:1];
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      push_q      <= push_d;
      ev_q        <= ev_d;
      overflow_q  <= overflow_q || fifo_drop;
    end
  end

`ifdef REPEAT_FILTER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_make_q     <= '0;
      last_make_vld_q <= 1'b0;
    end else begin
      last_make_q     <= last_make_d;
      last_make_vld_q <= last_make_vld_d;
    end
  end
`endif

  ps2_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_q),
    .wdata_i (ev_q),
    .pop_i   (key_rd),
    .rdata_o (head_raw),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .drop_o  (fifo_drop)
  );

  assign head         = key_event_t'(head_raw);
  assign key_valid    = !fifo_empty;
  assign key_code     = key_valid ? head.code : 8'h00;
  assign key_ext      = key_valid && head.ext;
  assign key_break    = key_valid && head.brk;
  assign rx_done_tick = rx_done;
  assign parity_err   = frame_err;
  assign dout         = dout_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: drives PS/2 frames at a 1 us ps2c period and
// compares the DUT against a queue-based model of the expected key events.
`timescale 1ns/1ps
module tb_ps2_key_receiver;

  localparam int FL = 8;
  localparam int FD = 8;
  localparam int TO = 1000;

  logic       clk = 1'b0, reset = 1'b1, ps2d = 1'b1, ps2c = 1'b1, rx_en = 1'b1, key_rd = 1'b0;
  logic       rx_done_tick, parity_err, key_valid, key_ext, key_break, fifo_full, overflow;
  logic [7:0] dout, key_code;

  always #5 clk = ~clk;

  ps2_key_receiver #(
    .FILTER_LEN     (FL),
    .FIFO_DEPTH     (FD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .rx_en        (rx_en),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .parity_err   (parity_err),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_break    (key_break),
    .key_rd       (key_rd),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         err_cnt  = 0;
  bit         settled  = 1'b0;

  // Model: expected FIFO contents {ext,brk,code}, last good byte, sticky overflow.
  logic [9:0] exp_q[$];
  logic [7:0] exp_dout = 8'h00;
  bit         exp_ovf  = 1'b0;
  bit         m_ext = 1'b0, m_brk = 1'b0;
  logic [8:0] m_last = '0;
  bit         m_last_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit keep;
    keep     = 1'b1;
    exp_dout = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
`ifdef REPEAT_FILTER_EN
      if (!m_brk) begin
        if (m_last_vld && m_last == {m_ext, b}) keep = 1'b0;
        else begin
          m_last     = {m_ext, b};
          m_last_vld = 1'b1;
        end
      end else if (m_last == {m_ext, b}) m_last_vld = 1'b0;
`endif
      if (keep) begin
        if (exp_q.size() == FD) exp_ovf = 1'b1;
        else exp_q.push_back({m_ext, m_brk, b});
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic drive_bits(input logic [10:0] f, input int nbits, input int drop_at);
    for (int i = 0; i < nbits; i++) begin
      if (i == drop_at) rx_en = 1'b0;
      ps2d = f[i];
      #250 ps2c = 1'b0;
      #500 ps2c = 1'b1;
      #250;
    end
    ps2d = 1'b1;
  endtask

  // Pops the head exactly in the cycle the next event is pushed.
  task automatic pop_watch();
    int k;
    k = 0;
    @(negedge clk);
    while (!rx_done_tick && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check("pop_watch timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk);
      #1 key_rd = 1'b1;
      void'(exp_q.pop_front());
      @(posedge clk);
      #1 key_rd = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bad, input bit exp_done, input bit exp_err,
                      input string name, input int drop_at, input bit pop_on_push);
    logic [10:0] f;
    settled  = 1'b0;
    done_cnt = 0;
    err_cnt  = 0;
    f = mk_frame(b, bad);
    if (pop_on_push) begin
      fork
        drive_bits(f, 11, drop_at);
        pop_watch();
      join
    end else begin
      drive_bits(f, 11, drop_at);
    end
    repeat (20) @(posedge clk);
    check({name, " rx_done_tick count"}, 32'(done_cnt), 32'(exp_done));
    check({name, " parity_err count"}, 32'(err_cnt), 32'(exp_err));
    if (exp_done) model_byte(b);
    rx_en   = 1'b1;
    settled = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic pop();
    settled = 1'b0;
    @(negedge clk);
    key_rd = 1'b1;
    @(posedge clk);
    #1 key_rd = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    settled = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    settled = 1'b0;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    exp_dout   = 8'h00;
    exp_ovf    = 1'b0;
    m_ext      = 1'b0;
    m_brk      = 1'b0;
    m_last_vld = 1'b0;
    repeat (2) @(posedge clk);
    settled = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  logic [7:0] fill_codes [10];
  int         n_rep;

  initial begin
    fill_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};

    fork
      forever begin
        @(negedge clk);
        if (rx_done_tick) done_cnt++;
        if (parity_err)   err_cnt++;
        if (settled) begin
          logic [9:0] h;
          check("key_valid", 32'(key_valid), 32'(exp_q.size() != 0));
          if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("key_code", 32'(key_code), 32'(h[7:0]));
            check("key_break", 32'(key_break), 32'(h[8]));
            check("key_ext", 32'(key_ext), 32'(h[9]));
          end
          check("fifo_full", 32'(fifo_full), 32'(exp_q.size() == FD));
          check("overflow", 32'(overflow), 32'(exp_ovf));
          check("dout", 32'(dout), 32'(exp_dout));
        end
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    do_reset();
    check("reset dout", 32'(dout), 32'h00);
    check("reset key_valid", 32'(key_valid), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);

    // Break of a plain key.
    send(8'hF0, 1'b0, 1'b1, 1'b0, "F0", -1, 1'b0);
    send(8'h2B, 1'b0, 1'b1, 1'b0, "2B", -1, 1'b0);
    check("lit dout 2B", 32'(dout), 32'h2B);
    check("lit code 2B", 32'(key_code), 32'h2B);
    check("lit brk 2B", 32'(key_break), 32'd1);
    check("lit ext 2B", 32'(key_ext), 32'd0);
    pop();

    // Extended break, then a plain make.
    send(8'hE0, 1'b0, 1'b1, 1'b0, "E0", -1, 1'b0);
    send(8'hF0, 1'b0, 1'b1, 1'b0, "F0b", -1, 1'b0);
    send(8'h75, 1'b0, 1'b1, 1'b0, "75", -1, 1'b0);
    check("lit code 75", 32'(key_code), 32'h75);
    check("lit ext 75", 32'(key_ext), 32'd1);
    check("lit brk 75", 32'(key_break), 32'd1);
    pop();
    send(8'h1C, 1'b0, 1'b1, 1'b0, "1C", -1, 1'b0);
    check("lit code 1C", 32'(key_code), 32'h1C);
    check("lit ext 1C", 32'(key_ext), 32'd0);
    check("lit brk 1C", 32'(key_break), 32'd0);
    pop();

    // Bad parity: rejected, dout keeps the previous byte.
    send(8'h1C, 1'b1, 1'b0, 1'b1, "1C badpar", -1, 1'b0);
    check("lit dout after badpar", 32'(dout), 32'h1C);
    check("lit key_valid after badpar", 32'(key_valid), 32'd0);

    // Partial frame abandoned by timeout, then a clean frame.
    settled  = 1'b0;
    done_cnt = 0;
    err_cnt  = 0;
    drive_bits(mk_frame(8'h2B, 1'b0), 5, -1);
    repeat (TO + 10) @(posedge clk);
    check("timeout parity_err count", 32'(err_cnt), 32'd1);
    check("timeout rx_done_tick count", 32'(done_cnt), 32'd0);
    settled = 1'b1;
    send(8'h2B, 1'b0, 1'b1, 1'b0, "2B after timeout", -1, 1'b0);
    check("lit code after timeout", 32'(key_code), 32'h2B);
    pop();

    // rx_en low ignores a frame; rx_en dropping mid-frame does not.
    rx_en = 1'b0;
    send(8'h2B, 1'b0, 1'b0, 1'b0, "rx_en low", -1, 1'b0);
    send(8'h2B, 1'b0, 1'b1, 1'b0, "rx_en drop", 3, 1'b0);
    pop();
    pop();

    // Typematic repeats of 1C followed by its break.
    send(8'h1C, 1'b0, 1'b1, 1'b0, "rep1", -1, 1'b0);
    send(8'h1C, 1'b0, 1'b1, 1'b0, "rep2", -1, 1'b0);
    send(8'h1C, 1'b0, 1'b1, 1'b0, "rep3", -1, 1'b0);
    send(8'hF0, 1'b0, 1'b1, 1'b0, "repF0", -1, 1'b0);
    send(8'h1C, 1'b0, 1'b1, 1'b0, "rep brk", -1, 1'b0);
`ifdef REPEAT_FILTER_EN
    n_rep = 2;
`else
    n_rep = 4;
`endif
    check("repeat model event count", 32'(exp_q.size()), 32'(n_rep));
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) pop();
    check("repeat drained", 32'(key_valid), 32'd0);

    // Reset during a frame: no pulses, everything back to zero.
    settled  = 1'b0;
    done_cnt = 0;
    err_cnt  = 0;
    drive_bits(mk_frame(8'h16, 1'b0), 5, -1);
    do_reset();
    repeat (2 * TO) @(posedge clk);
    check("midreset rx_done_tick count", 32'(done_cnt), 32'd0);
    check("midreset parity_err count", 32'(err_cnt), 32'd0);
    check("lit dout after reset", 32'(dout), 32'h00);

    // Fill the FIFO, push+pop while full, then overflow.
    for (int i = 0; i < FD; i++) send(fill_codes[i], 1'b0, 1'b1, 1'b0, "fill", -1, 1'b0);
    check("lit fifo_full after fill", 32'(fifo_full), 32'd1);
    check("lit overflow after fill", 32'(overflow), 32'd0);
    send(fill_codes[FD], 1'b0, 1'b1, 1'b0, "push+pop full", -1, 1'b1);
    check("lit overflow after push+pop", 32'(overflow), 32'd0);
    check("lit fifo_full after push+pop", 32'(fifo_full), 32'd1);
    check("lit head after push+pop", 32'(key_code), 32'h1E);
    send(fill_codes[FD+1], 1'b0, 1'b1, 1'b0, "overflow push", -1, 1'b0);
    check("lit overflow set", 32'(overflow), 32'd1);
    for (int i = 0; i < FD; i++) pop();
    check("lit drained key_valid", 32'(key_valid), 32'd0);
    check("lit drained fifo_full", 32'(fifo_full), 32'd0);
    pop();
    check("lit overflow sticky", 32'(overflow), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
